leb128_reader: RTL and testbench
================================

LEB128_READER -- requirements
Module: leb128_reader

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of cycles to wait for rom_ready per byte.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic on posedge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: begin a decode; sampled only in IDLE.
REQ-005 SHALL have port start_addr, input, 32 bits: byte address of the first LEB128 byte; sampled with start.
REQ-006 SHALL have port signed_mode, input, 1 bit: 0 = u32 decode, 1 = i32 decode; sampled with start.
REQ-007 SHALL have port rom_addr, output, 32 bits: byte address presented to the ROM.
REQ-008 SHALL have port rom_read_en, output, 1 bit: read request to the ROM.
REQ-009 SHALL have port rom_data, input, 8 bits: ROM byte, valid while rom_ready=1.
REQ-010 SHALL have port rom_ready, input, 1 bit: one-cycle ROM response pulse.
REQ-011 SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until done/error.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse at the end of every decode, whether successful or errored.
REQ-013 SHALL have port value, output, 32 bits: decoded value, held from done until the next accepted start.
REQ-014 SHALL have port next_addr, output, 32 bits: start_addr + byte_count, held like value.
REQ-015 SHALL have port byte_count, output, 3 bits: bytes consumed (1..5).
REQ-016 SHALL have port error, output, 1 bit: held with done; 1 = overlong encoding or timeout.

Function
REQ-017 SHALL implement states IDLE, FETCH, FINISH; FETCH holds rom_read_en=1, and rom_read_en=0 in all other states.
REQ-018 ROM model: ROM registers data on the posedge where rom_read_en=1 and rom_addr differs from its previous served address, then pulses rom_ready for one cycle. The reader SHALL present a new address (start_addr+i) for each byte i and never repeat an address within one decode.
REQ-019 IDLE + start=1 at cycle 0 -> FETCH at cycle 1 with rom_addr=start_addr, busy=1, accumulator=0, shift=0, count=0, error cleared.
REQ-020 In FETCH, on rom_ready=1: acc |= (rom_data[6:0] << shift) truncated to 32 bits; shift += 7; count += 1; rom_addr increments in the following cycle if rom_data[7]=1.
REQ-021 Latency: 2 cycles per byte; for an n-byte encoding starting at cycle 0, the final rom_ready occurs in cycle 2n and done=1 in cycle 2n+1.
REQ-022 Termination: on rom_ready with rom_data[7]=0 -> FINISH; in FINISH, value, next_addr and byte_count are updated, done=1, busy=0, then -> IDLE.
REQ-023 Signed: if signed_mode=1, the terminating byte has bit6=1, and shift after accumulation < 32, value SHALL be sign-extended from bit shift-1.
REQ-024 5th byte: only bits [3:0] are used; bits [6:4] are discarded silently.
REQ-025 5th byte: if rom_data[7]=1 -> error=1, byte_count=5, value=partial acc, next_addr=start_addr+5, and the block goes to FINISH.
REQ-026 Timeout: a per-byte counter resets on each address change; if it reaches TIMEOUT without rom_ready -> FINISH with error=1, byte_count=bytes received so far, value=partial acc.
REQ-027 start while busy or in FINISH SHALL be ignored; a start in the IDLE cycle immediately following FINISH SHALL be accepted.
REQ-028 rom_ready while in IDLE or FINISH SHALL be ignored.

Reset
REQ-029 rst=1 at any posedge -> IDLE next cycle; rom_read_en=0, rom_addr=0, busy=0, done=0, error=0, value=0, next_addr=0, byte_count=0.
REQ-030 Reset mid-FETCH SHALL abort the decode without asserting done; a late rom_ready after reset SHALL be ignored.

Verification
REQ-031 Bytes 0x08 at 0x10, u32, start at cycle 0 -> done at cycle 3, value=0x8, byte_count=1, next_addr=0x11, error=0.
REQ-032 Bytes E5 8E 26 at 0x40, u32 -> value=624485 (0x98765), byte_count=3, next_addr=0x43, done at cycle 7.
REQ-033 Byte 0x7F, signed_mode=1 -> value=0xFFFFFFFF; the same byte with signed_mode=0 -> value=0x7F.
REQ-034 Bytes FF FF FF FF 0F -> value=0xFFFFFFFF, error=0; bytes 80 80 80 80 80 -> error=1, byte_count=5, done asserted.
REQ-035 rom_ready held at 0 after start -> error=1, byte_count=0, and done exactly TIMEOUT+1 cycles after FETCH entry.
REQ-036 rst pulsed during the 2nd byte of E5 8E 26 -> no done, all outputs 0; a new start at 0x10 then decodes 0x08 correctly.

Source files
------------

// File: rtl/leb128_reader_if.sv
// leb128_reader_if -- byte-ROM read channel used by leb128_reader.
//   rom_addr    : byte address presented to the ROM (reader -> ROM)
//   rom_read_en : read request, held while the reader waits for a byte
//   rom_data    : ROM byte, valid while rom_ready = 1 (ROM -> reader)
//   rom_ready   : one-cycle response pulse
// The ROM answers once per new address, so the reader never repeats an
// address within one decode.
interface leb128_reader_if;
    logic [31:0] rom_addr;
    logic        rom_read_en;
    logic [7:0]  rom_data;
    logic        rom_ready;

    modport master (
        output rom_addr,
        output rom_read_en,
        input  rom_data,
        input  rom_ready
    );

    modport slave (
        input  rom_addr,
        input  rom_read_en,
        output rom_data,
        output rom_ready
    );
endinterface

// File: rtl/leb128_reader.sv
// leb128_reader -- fetches one LEB128 value (u32 or i32) byte by byte from a
// ROM and reports the decoded value, the byte count and the following address.
//   clk, rst    : clock, synchronous active-high reset
//   start       : begin a decode (accepted only in IDLE)
//   start_addr  : address of the first encoded byte, sampled with start
//   signed_mode : 0 = u32, 1 = i32 (sign-extended), sampled with start
//   rom         : ROM read channel (leb128_reader_if.master)
//   busy        : decode in progress
//   done        : one-cycle pulse at the end of every decode
//   value       : decoded (or partial) value, held until the next start
//   next_addr   : start_addr + byte_count, held like value
//   byte_count  : bytes consumed (0..5)
//   error       : overlong encoding or ROM timeout, held like value
module leb128_reader #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [31:0]     start_addr,
    input  logic            signed_mode,
    leb128_reader_if.master rom,
    output logic            busy,
    output logic            done,
    output logic [31:0]     value,
    output logic [31:0]     next_addr,
    output logic [2:0]      byte_count,
    output logic            error
);

    localparam int unsigned TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]    state_q,      state_d;
    logic [31:0]   addr_q,       addr_d;
    logic [31:0]   base_q,       base_d;
    logic          signed_q,     signed_d;
    logic [31:0]   acc_q,        acc_d;
    logic [5:0]    shift_q,      shift_d;
    logic [2:0]    count_q,      count_d;
    logic [TW-1:0] tmo_q,        tmo_d;
    logic [31:0]   value_q,      value_d;
    logic [31:0]   next_addr_q,  next_addr_d;
    logic [2:0]    byte_count_q, byte_count_d;
    logic          error_q,      error_d;

    logic [31:0]   acc_upd;
    logic [5:0]    shift_upd;
    logic [2:0]    count_upd;
    logic [31:0]   sign_mask;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        base_d       = base_q;
        signed_d     = signed_q;
        acc_d        = acc_q;
        shift_d      = shift_q;
        count_d      = count_q;
        tmo_d        = tmo_q;
        value_d      = value_q;
        next_addr_d  = next_addr_q;
        byte_count_d = byte_count_q;
        error_d      = error_q;

        // Truncation to 32 bits drops bits [6:4] of the fifth byte (shift 28).
        acc_upd   = acc_q | (32'(rom.rom_data[6:0]) << shift_q);
        shift_upd = shift_q + 6'd7;
        count_upd = count_q + 3'd1;
        sign_mask = {32{1'b1}} << shift_upd;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_FETCH;
                    addr_d   = start_addr;
                    base_d   = start_addr;
                    signed_d = signed_mode;
                    acc_d    = '0;
                    shift_d  = '0;
                    count_d  = '0;
                    tmo_d    = '0;
                    error_d  = 1'b0;
                end
            end
            S_FETCH: begin
                if (rom.rom_ready) begin
                    acc_d   = acc_upd;
                    shift_d = shift_upd;
                    count_d = count_upd;
                    tmo_d   = '0;
                    if (!rom.rom_data[7]) begin
                        state_d      = S_FINISH;
                        value_d      = (signed_q && rom.rom_data[6] && shift_upd < 6'd32)
                                       ? (acc_upd | sign_mask) : acc_upd;
                        next_addr_d  = base_q + 32'(count_upd);
                        byte_count_d = count_upd;
                        error_d      = 1'b0;
                    end else if (count_q == 3'd4) begin
                        // Continuation bit on the fifth byte: overlong encoding.
                        state_d      = S_FINISH;
                        value_d      = acc_upd;
                        next_addr_d  = base_q + 32'd5;
                        byte_count_d = 3'd5;
                        error_d      = 1'b1;
                    end else begin
                        addr_d = addr_q + 32'd1;
                    end
                end else if (tmo_q == TW'(TIMEOUT)) begin
                    state_d      = S_FINISH;
                    value_d      = acc_q;
                    next_addr_d  = base_q + 32'(count_q);
                    byte_count_d = count_q;
                    error_d      = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            base_q       <= '0;
            signed_q     <= 1'b0;
            acc_q        <= '0;
            shift_q      <= '0;
            count_q      <= '0;
            tmo_q        <= '0;
            value_q      <= '0;
            next_addr_q  <= '0;
            byte_count_q <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            base_q       <= base_d;
            signed_q     <= signed_d;
            acc_q        <= acc_d;
            shift_q      <= shift_d;
            count_q      <= count_d;
            tmo_q        <= tmo_d;
            value_q      <= value_d;
            next_addr_q  <= next_addr_d;
            byte_count_q <= byte_count_d;
            error_q      <= error_d;
        end
    end

    assign rom.rom_addr    = addr_q;
    assign rom.rom_read_en = (state_q == S_FETCH);
    assign busy            = (state_q == S_FETCH);
    assign done            = (state_q == S_FINISH);
    assign value           = value_q;
    assign next_addr       = next_addr_q;
    assign byte_count      = byte_count_q;
    assign error           = error_q;

endmodule

// File: tb/tb_leb128_reader.sv
module tb_leb128_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] start_addr = '0;
    logic        signed_mode = 1'b0;
    logic        busy, done, error;
    logic [31:0] value, next_addr;
    logic [2:0]  byte_count;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem [0:255];
    logic [31:0] last_addr = '0;
    bit          last_valid = 1'b0;
    bit          rom_stall = 1'b0;

    leb128_reader_if rif ();

    leb128_reader #(.TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_addr  (start_addr),
        .signed_mode (signed_mode),
        .rom         (rif),
        .busy        (busy),
        .done        (done),
        .value       (value),
        .next_addr   (next_addr),
        .byte_count  (byte_count),
        .error       (error)
    );

    always #5 clk = ~clk;

    // ROM: serves once per new address, response one cycle after the request edge.
    always @(posedge clk) begin
        rif.rom_ready <= 1'b0;
        if (rif.rom_read_en === 1'b1 && !rom_stall &&
            !(last_valid && rif.rom_addr == last_addr)) begin
            rif.rom_data  <= mem[rif.rom_addr[7:0]];
            rif.rom_ready <= 1'b1;
            last_addr     <= rif.rom_addr;
            last_valid    <= 1'b1;
        end
    end

    // Start a decode in cycle 0 and run until done (bounded); cyc is the done cycle.
    task automatic do_decode(input logic [31:0] a, input logic sm, input int glitch,
                             output int cyc, output logic [31:0] addr1, output logic busy1);
        @(posedge clk); #1;
        start = 1'b1; start_addr = a; signed_mode = sm; cyc = 0;
        @(posedge clk); #1;
        start = 1'b0; start_addr = '0; cyc = 1;
        addr1 = rif.rom_addr; busy1 = busy;
        while (done !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == glitch) begin
                start = 1'b1; start_addr = 32'h99; signed_mode = ~sm;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rif.rom_read_en !== 1'b0) begin errors++; $display("FAIL reset_read_en: got %b expected 0", rif.rom_read_en); end
        checks++; if (rif.rom_addr !== 32'h0) begin errors++; $display("FAIL reset_rom_addr: got %h expected 0", rif.rom_addr); end
        checks++; if ({busy, done, error} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {busy, done, error}); end
        checks++; if ({value, next_addr, byte_count} !== 67'h0) begin errors++; $display("FAIL reset_outputs: got %h/%h/%0d expected 0/0/0", value, next_addr, byte_count); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int cyc; logic [31:0] a1; logic b1;
        do_decode(32'h10, 1'b0, 0, cyc, a1, b1);
        checks++; if (a1 !== 32'h10 || b1 !== 1'b1) begin errors++; $display("FAIL single_fetch_entry: got addr %h busy %b expected 10 1", a1, b1); end
        checks++; if (cyc !== 3) begin errors++; $display("FAIL single_done_cycle: got %0d expected 3", cyc); end
        checks++; if (value !== 32'h8) begin errors++; $display("FAIL single_value: got %h expected 8", value); end
        checks++; if (byte_count !== 3'd1 || next_addr !== 32'h11 || error !== 1'b0) begin errors++; $display("FAIL single_meta: got %0d/%h/%b expected 1/11/0", byte_count, next_addr, error); end
    endtask

    task automatic test_multi();
        int cyc; logic [31:0] a1; logic b1;
        // A start pulse mid-decode (cycle 3) must be ignored.
        do_decode(32'h40, 1'b0, 3, cyc, a1, b1);
        checks++; if (cyc !== 7) begin errors++; $display("FAIL multi_done_cycle: got %0d expected 7", cyc); end
        checks++; if (value !== 32'h98765) begin errors++; $display("FAIL multi_value: got %h expected 98765", value); end
        checks++; if (byte_count !== 3'd3 || next_addr !== 32'h43 || error !== 1'b0) begin errors++; $display("FAIL multi_meta: got %0d/%h/%b expected 3/43/0", byte_count, next_addr, error); end
    endtask

    task automatic test_back_to_back();
        int cyc; logic [31:0] a1; logic b1;
        do_decode(32'h20, 1'b1, 0, cyc, a1, b1);
        checks++; if (value !== 32'hFFFF_FFFF || cyc !== 3) begin errors++; $display("FAIL signed_7f: got %h at %0d expected ffffffff at 3", value, cyc); end
        // Next start lands in the IDLE cycle right after FINISH.
        do_decode(32'h30, 1'b0, 0, cyc, a1, b1);
        checks++; if (value !== 32'h7F || cyc !== 3 || a1 !== 32'h30) begin errors++; $display("FAIL b2b_unsigned_7f: got %h at %0d addr %h expected 7f at 3 addr 30", value, cyc, a1); end
        // Start asserted only during FINISH must be ignored.
        start = 1'b1; start_addr = 32'h20; signed_mode = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || rif.rom_read_en !== 1'b0 || value !== 32'h7F) begin errors++; $display("FAIL finish_start_ignored: got busy %b rd %b value %h expected 0 0 7f", busy, rif.rom_read_en, value); end
        do_decode(32'h80, 1'b1, 0, cyc, a1, b1);
        checks++; if (value !== 32'hFFFE_1DC0 || cyc !== 7) begin errors++; $display("FAIL signed_3byte: got %h at %0d expected fffe1dc0 at 7", value, cyc); end
    endtask

    task automatic test_five_byte();
        int cyc; logic [31:0] a1; logic b1;
        do_decode(32'h50, 1'b0, 0, cyc, a1, b1);
        checks++; if (value !== 32'hFFFF_FFFF || error !== 1'b0 || cyc !== 11) begin errors++; $display("FAIL max_u32: got %h err %b at %0d expected ffffffff 0 at 11", value, error, cyc); end
        checks++; if (byte_count !== 3'd5 || next_addr !== 32'h55) begin errors++; $display("FAIL max_u32_meta: got %0d/%h expected 5/55", byte_count, next_addr); end
        do_decode(32'h58, 1'b0, 0, cyc, a1, b1);
        checks++; if (value !== 32'hF000_0000 || error !== 1'b0) begin errors++; $display("FAIL fifth_byte_mask: got %h err %b expected f0000000 0", value, error); end
        do_decode(32'h60, 1'b0, 0, cyc, a1, b1);
        checks++; if (error !== 1'b1 || byte_count !== 3'd5 || cyc !== 11) begin errors++; $display("FAIL overlong: got err %b count %0d at %0d expected 1 5 at 11", error, byte_count, cyc); end
        checks++; if (value !== 32'h0 || next_addr !== 32'h65) begin errors++; $display("FAIL overlong_meta: got %h/%h expected 0/65", value, next_addr); end
    endtask

    task automatic test_timeout();
        int cyc; logic [31:0] a1; logic b1;
        rom_stall = 1'b1;
        do_decode(32'h70, 1'b0, 0, cyc, a1, b1);
        rom_stall = 1'b0;
        checks++; if (cyc !== 18) begin errors++; $display("FAIL timeout_cycle: got %0d expected 18", cyc); end
        checks++; if (error !== 1'b1 || byte_count !== 3'd0 || value !== 32'h0 || next_addr !== 32'h70) begin errors++; $display("FAIL timeout_meta: got %b/%0d/%h/%h expected 1/0/0/70", error, byte_count, value, next_addr); end
    endtask

    task automatic test_reset_abort();
        int cyc; logic [31:0] a1; logic b1; bit saw_done;
        saw_done = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; start_addr = 32'h40; signed_mode = 1'b0;
        @(posedge clk); #1; start = 1'b0;   // cycle 1
        @(posedge clk); #1;                 // cycle 2: first byte returns
        @(posedge clk); #1; rst = 1'b1;     // cycle 3: second byte requested
        @(posedge clk); #1; rst = 1'b0;     // cycle 4: late rom_ready arrives
        checks++; if ({busy, done, error, rif.rom_read_en} !== 4'b0 || rif.rom_addr !== 32'h0) begin errors++; $display("FAIL abort_flags: got %b addr %h expected 0000 0", {busy, done, error, rif.rom_read_en}, rif.rom_addr); end
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (saw_done !== 1'b0 || {value, next_addr, byte_count} !== 67'h0) begin errors++; $display("FAIL abort_outputs: got done %b %h/%h/%0d expected 0 0/0/0", saw_done, value, next_addr, byte_count); end
        do_decode(32'h10, 1'b0, 0, cyc, a1, b1);
        checks++; if (value !== 32'h8 || byte_count !== 3'd1 || next_addr !== 32'h11 || cyc !== 3) begin errors++; $display("FAIL after_abort: got %h/%0d/%h at %0d expected 8/1/11 at 3", value, byte_count, next_addr, cyc); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h08;
        mem[8'h40] = 8'hE5; mem[8'h41] = 8'h8E; mem[8'h42] = 8'h26;
        mem[8'h20] = 8'h7F;
        mem[8'h30] = 8'h7F;
        mem[8'h80] = 8'hC0; mem[8'h81] = 8'hBB; mem[8'h82] = 8'h78;
        for (int i = 0; i < 4; i++) begin
            mem[8'h50 + i] = 8'hFF;
            mem[8'h58 + i] = 8'h80;
            mem[8'h60 + i] = 8'h80;
        end
        mem[8'h54] = 8'h0F;
        mem[8'h5C] = 8'h7F;
        mem[8'h64] = 8'h80;

        test_reset();
        test_single();
        test_multi();
        test_back_to_back();
        test_five_byte();
        test_timeout();
        test_reset_abort();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
